// File: rtl/iq_issue_sched.sv
// iq_issue_sched: issue scheduler for the 16-entry centralized issue queue.
//
// Tracks each entry's lifecycle (IDLE / WAIT / ISSUED) and age. Every cycle it picks the two
// oldest ready entries for FU ports 0 and 1, using a same-cycle valid/ready handshake.
//
// Optional feature, enabled when the macro IQ_SCHED_REPLAY_EN is defined:
//   A fired entry stays ISSUED for REPLAY_WIN cycles. During that time replay_vec can send
//   it back to WAIT. When the macro is undefined, a fired entry goes straight to IDLE and
//   replay_vec is ignored.
//
// Ports:
//   clk, rst_n              clock; asynchronous active-low reset
//   alloc_vec[15:0]         dispatch writes entry i this cycle (IDLE entries only)
//   rdy_vec[15:0]           all sources of entry i are ready (combinational from wakeup)
//   replay_vec[15:0]        entry i must re-issue (load-miss replay)
//   flush                   clears the whole queue at the next edge
//   fu0_ready, fu1_ready    FU port accepts an instruction
//   iss0_valid, iss0_idx    port 0 candidate (oldest ready entry)
//   iss1_valid, iss1_idx    port 1 candidate (next oldest ready entry)
//   free_vec[15:0]          entry i is IDLE
//   iq_count[4:0]           number of non-IDLE entries (registered)
module iq_issue_sched #(
    parameter int unsigned ENTRIES    = 16,
    parameter int unsigned AGE_W      = 5,
    parameter int unsigned REPLAY_WIN = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ENTRIES-1:0] alloc_vec,
    input  logic [ENTRIES-1:0] rdy_vec,
    input  logic [ENTRIES-1:0] replay_vec,
    input  logic               flush,
    input  logic               fu0_ready,
    input  logic               fu1_ready,
    output logic               iss0_valid,
    output logic [3:0]         iss0_idx,
    output logic               iss1_valid,
    output logic [3:0]         iss1_idx,
    output logic [ENTRIES-1:0] free_vec,
    output logic [4:0]         iq_count
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StWait   = 2'd1,
        StIssued = 2'd2
    } ent_state_e;

    localparam logic [AGE_W-1:0] AgeMax = '1;

    ent_state_e       state_q [ENTRIES];
    ent_state_e       state_d [ENTRIES];
    logic [AGE_W-1:0] age_q   [ENTRIES];
    logic [AGE_W-1:0] age_d   [ENTRIES];
    logic [4:0]       count_d;

`ifdef IQ_SCHED_REPLAY_EN
    localparam logic [1:0] WinLast = 2'(REPLAY_WIN - 1);
    logic [1:0] win_q [ENTRIES];
    logic [1:0] win_d [ENTRIES];
`else
    // Replay hardware is absent in this build.
    logic unused_replay;
    assign unused_replay = ^replay_vec;
    localparam int unsigned unused_replay_win = REPLAY_WIN;
`endif

    logic [ENTRIES-1:0] elig;
    logic [ENTRIES-1:0] fired;
    logic               sel0_vld, sel1_vld;
    logic [3:0]         sel0_idx, sel1_idx;
    logic [AGE_W-1:0]   sel0_age, sel1_age;

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            elig[i]     = (state_q[i] == StWait) && rdy_vec[i];
            free_vec[i] = (state_q[i] == StIdle);
        end
    end

    // Oldest eligible entry. The strict '>' keeps the lower index on equal ages.
    always_comb begin
        sel0_vld = 1'b0;
        sel0_idx = '0;
        sel0_age = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (elig[i] && (!sel0_vld || (age_q[i] > sel0_age))) begin
                sel0_vld = 1'b1;
                sel0_idx = 4'(i);
                sel0_age = age_q[i];
            end
        end
    end

    // Oldest eligible entry other than the port-0 pick.
    always_comb begin
        sel1_vld = 1'b0;
        sel1_idx = '0;
        sel1_age = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (elig[i] && !(sel0_vld && (sel0_idx == 4'(i))) &&
                (!sel1_vld || (age_q[i] > sel1_age))) begin
                sel1_vld = 1'b1;
                sel1_idx = 4'(i);
                sel1_age = age_q[i];
            end
        end
    end

    assign iss0_valid = sel0_vld;
    assign iss0_idx   = sel0_idx;
    assign iss1_valid = sel1_vld;
    assign iss1_idx   = sel1_idx;

    // Ports fire independently. An unfired port-0 candidate is never moved to port 1.
    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            fired[i] = (sel0_vld && fu0_ready && (sel0_idx == 4'(i))) ||
                       (sel1_vld && fu1_ready && (sel1_idx == 4'(i)));
        end
    end

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            state_d[i] = state_q[i];
            age_d[i]   = age_q[i];
`ifdef IQ_SCHED_REPLAY_EN
            win_d[i]   = win_q[i];
`endif
            if (flush) begin
                state_d[i] = StIdle;
                age_d[i]   = '0;
            end else begin
                unique case (state_q[i])
                    StIdle: begin
                        if (alloc_vec[i]) begin
                            state_d[i] = StWait;
                            age_d[i]   = '0;
                        end
                    end
                    StWait: begin
                        if (age_q[i] != AgeMax) begin
                            age_d[i] = age_q[i] + 1'b1;
                        end
                        if (fired[i]) begin
`ifdef IQ_SCHED_REPLAY_EN
                            state_d[i] = StIssued;
                            win_d[i]   = '0;
`else
                            state_d[i] = StIdle;
`endif
                        end
                    end
                    StIssued: begin
`ifdef IQ_SCHED_REPLAY_EN
                        // Replay takes priority over release in the same cycle.
                        if (replay_vec[i]) begin
                            state_d[i] = StWait;
                        end else if (win_q[i] == WinLast) begin
                            state_d[i] = StIdle;
                        end else begin
                            win_d[i] = win_q[i] + 2'd1;
                        end
`else
                        state_d[i] = StIdle;
`endif
                    end
                    default: state_d[i] = StIdle;
                endcase
            end
        end
    end

    always_comb begin
        count_d = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (state_d[i] != StIdle) begin
                count_d = count_d + 5'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                state_q[i] <= StIdle;
                age_q[i]   <= '0;
`ifdef IQ_SCHED_REPLAY_EN
                win_q[i]   <= '0;
`endif
            end
            iq_count <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                state_q[i] <= state_d[i];
                age_q[i]   <= age_d[i];
`ifdef IQ_SCHED_REPLAY_EN
                win_q[i]   <= win_d[i];
`endif
            end
            iq_count <= count_d;
        end
    end

endmodule

// File: tb/tb_iq_issue_sched.sv
// Testbench for iq_issue_sched: directed scenarios plus randomized traffic, checked against
// a behavioural queue model (entry status, cycles waited, release edge number).
module tb_iq_issue_sched;

    localparam int RW      = 2;
    localparam int AGE_MAX = 31;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] alloc_vec, rdy_vec, replay_vec;
    logic        flush, fu0_ready, fu1_ready;
    logic        iss0_valid, iss1_valid;
    logic [3:0]  iss0_idx, iss1_idx;
    logic [15:0] free_vec;
    logic [4:0]  iq_count;

    always #5 clk = ~clk;

    iq_issue_sched #(
        .ENTRIES   (16),
        .AGE_W     (5),
        .REPLAY_WIN(RW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alloc_vec (alloc_vec),
        .rdy_vec   (rdy_vec),
        .replay_vec(replay_vec),
        .flush     (flush),
        .fu0_ready (fu0_ready),
        .fu1_ready (fu1_ready),
        .iss0_valid(iss0_valid),
        .iss0_idx  (iss0_idx),
        .iss1_valid(iss1_valid),
        .iss1_idx  (iss1_idx),
        .free_vec  (free_vec),
        .iq_count  (iq_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: status 0 = free, 1 = waiting, 2 = issued; age = cycles spent waiting (capped);
    // rel = edge number at which an issued entry returns to free.
    int m_st  [16];
    int m_age [16];
    int m_rel [16];
    int edges = 0;

    logic       sv0, sv1;
    logic [3:0] si0, si1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_st[i]  = 0;
            m_age[i] = 0;
            m_rel[i] = 0;
        end
    endtask

    function automatic logic [15:0] model_free();
        logic [15:0] f;
        for (int i = 0; i < 16; i++) f[i] = (m_st[i] == 0);
        return f;
    endfunction

    function automatic logic [4:0] model_count();
        int c = 0;
        for (int i = 0; i < 16; i++) if (m_st[i] != 0) c++;
        return 5'(c);
    endfunction

    // Rank ready waiting entries by (age, lower index) and keep the top two in one pass.
    task automatic model_select();
        int k0, k1, b0, b1, key;
        k0 = -1; k1 = -1; b0 = 0; b1 = 0;
        for (int i = 0; i < 16; i++) begin
            if (m_st[i] == 1 && rdy_vec[i]) begin
                key = m_age[i] * 16 + (15 - i);
                if (key > k0) begin
                    k1 = k0; b1 = b0; k0 = key; b0 = i;
                end else if (key > k1) begin
                    k1 = key; b1 = i;
                end
            end
        end
        sv0 = (k0 >= 0);
        sv1 = (k1 >= 0);
        si0 = sv0 ? 4'(b0) : 4'd0;
        si1 = sv1 ? 4'(b1) : 4'd0;
    endtask

    // Sample outputs on the falling edge and compare with the model.
    task automatic settle();
        @(negedge clk);
        model_select();
        chk("iss0_valid", iss0_valid, sv0);
        chk("iss0_idx", iss0_idx, si0);
        chk("iss1_valid", iss1_valid, sv1);
        chk("iss1_idx", iss1_idx, si1);
        chk("free_vec", free_vec, model_free());
        chk("iq_count", iq_count, model_count());
    endtask

    // Advance the model across one rising edge, then let inputs change 1 time unit later.
    task automatic tick();
        logic [15:0] fired;
        @(posedge clk);
        fired = '0;
        if (sv0 && fu0_ready) fired[si0] = 1'b1;
        if (sv1 && fu1_ready) fired[si1] = 1'b1;
        edges++;
        for (int i = 0; i < 16; i++) begin
            if (flush) begin
                m_st[i]  = 0;
                m_age[i] = 0;
            end else if (m_st[i] == 0) begin
                if (alloc_vec[i]) begin
                    m_st[i]  = 1;
                    m_age[i] = 0;
                end
            end else if (m_st[i] == 1) begin
                m_age[i] = (m_age[i] < AGE_MAX) ? m_age[i] + 1 : AGE_MAX;
                if (fired[i]) begin
`ifdef IQ_SCHED_REPLAY_EN
                    m_st[i]  = 2;
                    m_rel[i] = edges + RW;
`else
                    m_st[i]  = 0;
`endif
                end
            end else begin
                if (replay_vec[i]) m_st[i] = 1;
                else if (edges == m_rel[i]) m_st[i] = 0;
            end
        end
        #1;
    endtask

    task automatic cyc();
        settle();
        tick();
    endtask

    task automatic idle_inputs();
        alloc_vec  = '0;
        rdy_vec    = '0;
        replay_vec = '0;
        flush      = 1'b0;
        fu0_ready  = 1'b1;
        fu1_ready  = 1'b1;
    endtask

    task automatic drain();
        idle_inputs();
        rdy_vec = 16'hFFFF;
        repeat (6) cyc();
        rdy_vec = '0;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_free"}, free_vec, 16'hFFFF);
        chk({tag, "_count"}, iq_count, 5'd0);
        chk({tag, "_v0"}, iss0_valid, 1'b0);
        chk({tag, "_v1"}, iss1_valid, 1'b0);
        chk({tag, "_i0"}, iss0_idx, 4'd0);
        chk({tag, "_i1"}, iss1_idx, 4'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset_checks("rst");
        rst_n = 1'b1;

        // Age order: 5, then 2, then 9; all made ready together.
        alloc_vec = 16'h0020; cyc();
        alloc_vec = 16'h0004; cyc();
        alloc_vec = 16'h0200; cyc();
        alloc_vec = 16'h0000; cyc();
        rdy_vec = 16'h0224;
        settle();
        chk("age_p0", iss0_idx, 4'd5);
        chk("age_p1", iss1_idx, 4'd2);
        tick();
        settle();
        chk("age_next_p0", iss0_idx, 4'd9);
        chk("age_next_v1", iss1_valid, 1'b0);
        tick();
        drain();

        // Tie-break: equal ages resolve to the lower index.
        alloc_vec = 16'h0088; cyc();
        alloc_vec = 16'h0000; rdy_vec = 16'h0088;
        settle();
        chk("tie_p0", iss0_idx, 4'd3);
        chk("tie_p1", iss1_idx, 4'd7);
        tick();
        drain();

        // Backpressure on port 0 with a single ready entry.
        alloc_vec = 16'h0010; cyc();
        alloc_vec = 16'h0000; rdy_vec = 16'h0010; fu0_ready = 1'b0;
        repeat (3) begin
            settle();
            chk("bp_v0", iss0_valid, 1'b1);
            chk("bp_idx", iss0_idx, 4'd4);
            chk("bp_v1", iss1_valid, 1'b0);
            chk("bp_busy", free_vec[4], 1'b0);
            tick();
        end
        fu0_ready = 1'b1;
        settle();
        chk("bp_fire_v0", iss0_valid, 1'b1);
        tick();
        settle();
        chk("bp_after_v0", iss0_valid, 1'b0);
        tick();
        drain();

        // Replay of entry 6.
        alloc_vec = 16'h0040; cyc();
        alloc_vec = 16'h0000; rdy_vec = 16'h0040;
        settle();
        chk("rp_sel", iss0_idx, 4'd6);
        tick();
        rdy_vec = 16'h0000; replay_vec = 16'h0040;
`ifdef IQ_SCHED_REPLAY_EN
        settle();
        chk("rp_held", free_vec[6], 1'b0);
        tick();
        replay_vec = 16'h0000; rdy_vec = 16'h0040;
        settle();
        chk("rp_resel_v", iss0_valid, 1'b1);
        chk("rp_resel_i", iss0_idx, 4'd6);
        tick();
        rdy_vec = 16'h0000;
        settle();
        chk("rp_win1", free_vec[6], 1'b0);
        tick();
        settle();
        chk("rp_win2", free_vec[6], 1'b0);
        tick();
        settle();
        chk("rp_release", free_vec[6], 1'b1);
        tick();
`else
        settle();
        chk("rp_release", free_vec[6], 1'b1);
        tick();
        replay_vec = 16'h0000;
        settle();
        chk("rp_ignored", iq_count, 5'd0);
        tick();
`endif
        drain();

        // Age saturation: entry 8 waits 35 cycles (capped at 31), entry 0 waits 4.
        alloc_vec = 16'h0100; cyc();
        alloc_vec = 16'h0000;
        repeat (30) cyc();
        alloc_vec = 16'h0001; cyc();
        alloc_vec = 16'h0000;
        repeat (4) cyc();
        rdy_vec = 16'h0101;
        settle();
        chk("sat_p0", iss0_idx, 4'd8);
        chk("sat_p1", iss1_idx, 4'd0);
        tick();
        drain();

        // Flush with ten occupied entries and a simultaneous allocation.
        alloc_vec = 16'h07FE; cyc();
        alloc_vec = 16'h0000;
        settle();
        chk("fl_count_pre", iq_count, 5'd10);
        tick();
        flush = 1'b1; alloc_vec = 16'h0001;
        cyc();
        flush = 1'b0; alloc_vec = 16'h0000;
        settle();
        chk("fl_free", free_vec, 16'hFFFF);
        chk("fl_count", iq_count, 5'd0);
        tick();

        // Randomized traffic with a mid-traffic reset.
        for (int n = 0; n < 600; n++) begin
            alloc_vec  = 16'($urandom) & 16'($urandom) & model_free();
            if (n < 200) rdy_vec = 16'($urandom) & 16'($urandom) & 16'($urandom);
            else rdy_vec = 16'($urandom);
            replay_vec = 16'($urandom) & 16'($urandom) & 16'($urandom);
            flush      = ($urandom_range(0, 63) == 0);
            fu0_ready  = ($urandom_range(0, 3) != 0);
            fu1_ready  = ($urandom_range(0, 3) != 0);
            cyc();
            if (n == 300) begin
                rst_n = 1'b0;
                #2;
                reset_checks("mid_rst");
                idle_inputs();
                model_reset();
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/iq_issue_sched.md
# iq_issue_sched

Issue scheduler for the 16-entry centralized issue queue. Tracks per-entry lifecycle (free / waiting / issued), ages waiting entries, and each cycle selects the two oldest ready entries for two functional-unit issue ports with a valid/ready handshake. Holds issued entries in a short speculative window so a load-miss replay can return them to waiting. Sits between the queue's allocation/wakeup logic and the FU issue ports, and publishes the free-entry vector used by dispatch.

## Interface
Parameters:
- `ENTRIES`, 16, queue depth (index width fixed at 4)
- `AGE_W`, 5, age counter width
- `REPLAY_WIN`, 2, cycles an issued entry is held before release (1..3)

Ports:
- `clk` in 1: clock
- `rst_n` in 1: reset; one clock; reset is asynchronous and active-low
- `alloc_vec` in 16: entry i written by dispatch this cycle
- `rdy_vec` in 16: all valid sources of entry i ready (from wakeup, combinational)
- `replay_vec` in 16: entry i must re-issue (replay)
- `flush` in 1: pipeline flush, clears whole queue
- `fu0_ready`, `fu1_ready` in 1 each: FU port accepts an instruction
- `iss0_valid`, `iss1_valid` out 1 each: issue candidate present
- `iss0_idx`, `iss1_idx` out 4 each: selected entry index
- `free_vec` out 16: entry i is free (state IDLE)
- `iq_count` out 5: number of non-IDLE entries

## Operation
- Per-entry state: IDLE, WAIT, ISSUED; plus `age[AGE_W-1:0]` and 2-bit `win` timer.
- IDLE -> WAIT on `alloc_vec[i]`; age := 0. Alloc to non-IDLE entry ignored (bench flags as error).
- WAIT: age += 1 per cycle, saturating at 2^AGE_W-1. Eligible when `rdy_vec[i]`.
- Select (combinational from registered state + `rdy_vec`): port 0 = eligible entry with greatest age; port 1 = greatest age among the rest. Equal ages: lower index wins. `issN_valid`=0 and `issN_idx`=0 when no candidate.
- Fire N = `issN_valid & fuN_ready`; ports fire independently. A port-0 candidate not fired is not re-routed to port 1 that cycle.
- WAIT -> ISSUED on fire; win := 0; age frozen.
- ISSUED: win += 1 per cycle; `replay_vec[i]` -> WAIT (age kept, resumes incrementing); else when win == REPLAY_WIN-1 -> IDLE. Replay wins over release in the same cycle. `replay_vec` on IDLE/WAIT entries ignored.
- `flush`: all entries IDLE next edge; overrides alloc, fire, replay in that cycle.
- `free_vec[i]` = (state==IDLE), from registered state; `iq_count` registered population count of non-IDLE entries.

## Timing
- Reset values: all entries IDLE, ages 0, `free_vec`=16'hFFFF, `iq_count`=0, `iss0/1_valid`=0, `iss0/1_idx`=0.
- Allocation in cycle N: entry eligible for select in N+1 (if `rdy_vec` high); `free_vec[i]` drops at N+1.
- Select-to-fire: zero cycles (same-cycle handshake); state changes at following edge.
- Release: entry fired at edge E becomes IDLE at edge E+REPLAY_WIN; `free_vec` high from then, re-allocatable same cycle.
- Reset asserted mid-operation: immediate return to reset values; no partial issue.

## Configuration
- `IQ_SCHED_REPLAY_EN` defined: ISSUED state, `win` timer, and `replay_vec` behave as above.
- Not defined: `replay_vec` ignored, no timers; fired entry goes WAIT -> IDLE at the next edge (REPLAY_WIN treated as 1).

## Test plan
- Reset: assert `rst_n`=0 mid-traffic -> `free_vec`=16'hFFFF, `iq_count`=0, both valids 0 immediately.
- Age order: alloc entry 5 at cycle 0, entry 2 at cycle 1, entry 9 at cycle 2, all ready cycle 4, both FUs ready -> port0=5, port1=2; next cycle port0=9.
- Tie-break: alloc entries 7 and 3 same cycle, ready -> `iss0_idx`=3, `iss1_idx`=7.
- Backpressure: `fu0_ready`=0, single ready entry 4 -> `iss0_valid`=1 idx 4 held stable, `iss1_valid`=0, entry stays WAIT until `fu0_ready`=1.
- Replay (REPLAY_WIN=2): fire entry 6 at edge E, `replay_vec[6]` next cycle -> entry 6 back in WAIT, reselected; without replay `free_vec[6]`=1 at E+2.
- Flush: 10 entries occupied, `flush` with simultaneous alloc of entry 0 -> next cycle `free_vec`=16'hFFFF, `iq_count`=0.
